// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: frame state encoding, TX line mux selects and line constants
// shared by the UART transmit frame controller.
// Macro UART_TX_PARITY_EN adds the PARITY state to the enumeration.
package uart_tx_pkg;

    // Line levels for the framing bits.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame controller states. Encodings are fixed so that a debug probe
    // reads the same value whether or not parity support is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    // Selects for the TX output mux.
    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_DATA   = 2'd1,
        SEL_PARITY = 2'd2,
        SEL_STOP   = 2'd3
    } tx_sel_t;

    // Line value for a given mux select. Idle and stop both drive the
    // marking level, so anything unrecognised falls back to STOP_BIT.
    function automatic logic tx_line_mux(input tx_sel_t sel,
                                         input logic    data_bit,
                                         input logic    parity_bit);
        logic line;
        case (sel)
            SEL_START:  line = START_BIT;
            SEL_DATA:   line = data_bit;
            SEL_PARITY: line = parity_bit;
            default:    line = STOP_BIT;
        endcase
        return line;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity of a data word.
// odd=0 gives the plain XOR of all bits, odd=1 gives its inverse.
// Only built when UART_TX_PARITY_EN is defined; the parity-less frame
// controller has no use for it.
`ifdef UART_TX_PARITY_EN
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  odd,
    output logic                  parity
);

    // Reduction XOR, optionally inverted for odd parity.
    always_comb begin
        parity = (^data) ^ odd;
    end

endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller. Accepts a byte, drives the
// external serializer, and muxes start/data/parity/stop bits onto TX_OUT.
// One UART bit per CLK cycle. TX_OUT and busy are registered from the
// current state, so the line lags the state register by one cycle.
// Macro UART_TX_PARITY_EN adds PAR_EN/PAR_TYP, the PARITY state and the
// parity generator; without it every frame is start + data + stop.
//
// Host handshake: there is no ready signal. DATA_VALID=1 is accepted on a
// clock edge where the controller is in IDLE or STOP; P_DATA (and the parity
// controls) are captured on that edge. In every other state DATA_VALID is
// ignored and nothing is queued, so the host must hold or re-present it.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`endif
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_err,
    output tx_state_t             state_dbg
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_t        state;
    tx_state_t        next_state;
    tx_sel_t          line_sel;
    logic             busy_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             cnt_last;
    logic             data_last;
    logic             count_mismatch;
    logic             parity_bit;

    assign state_dbg = state;

    // A byte is taken only when the line is idle or finishing a stop bit.
    assign accept = DATA_VALID && ((state == ST_IDLE) || (state == ST_STOP));

    // DATA ends on whichever of serializer done / local count comes first;
    // the two disagreeing is the frame error condition.
    assign cnt_last       = (bit_cnt == CNT_LAST);
    assign data_last      = (state == ST_DATA) && (ser_done || cnt_last);
    assign count_mismatch = (state == ST_DATA) && (ser_done != cnt_last);

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;

    // Parity controls are frozen for the whole frame at acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Parity is taken from the latched byte, never the live P_DATA.
    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (ser_p_data),
        .odd    (par_typ_q),
        .parity (parity_bit)
    );
`else
    assign parity_bit = STOP_BIT;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, line select, busy and serializer enable for the current state.
    always_comb begin
        next_state = state;
        line_sel   = SEL_STOP;
        busy_next  = 1'b1;
        ser_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (accept) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                line_sel   = SEL_START;
                ser_en     = 1'b1;
                next_state = ST_DATA;
            end
            ST_DATA: begin
                line_sel = SEL_DATA;
                ser_en   = 1'b1;
                if (data_last) begin
`ifdef UART_TX_PARITY_EN
                    next_state = par_en_q ? ST_PARITY : ST_STOP;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                line_sel   = SEL_PARITY;
                next_state = ST_STOP;
            end
`endif
            ST_STOP: begin
                line_sel   = SEL_STOP;
                next_state = accept ? ST_START : ST_IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered line and busy; reset drives the line to mark immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT <= STOP_BIT;
            busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_line_mux(line_sel, ser_data, parity_bit);
            busy   <= busy_next;
        end
    end

    // Data bit counter: restarts at zero every time DATA is entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (state == ST_DATA) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
            bit_cnt <= '0;
        end
    end

    // Byte latch feeding the serializer, loaded only on acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_p_data <= '0;
        end else if (accept) begin
            ser_p_data <= P_DATA;
        end
    end

    // Sticky frame error; only reset clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_err <= 1'b0;
        end else if (count_mismatch) begin
            frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl with a behavioural
// serializer and a line-level frame model. Works with or without
// UART_TX_PARITY_EN defined.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK_tb;
    logic         RST_tb;
    logic [W-1:0] P_DATA_tb;
    logic         DATA_VALID_tb;
    logic         PAR_EN_tb;
    logic         PAR_TYP_tb;
    logic         ser_data_tb;
    logic         ser_done_tb;
    logic [W-1:0] ser_p_data_tb;
    logic         ser_en_tb;
    logic         TX_OUT_tb;
    logic         busy_tb;
    logic         frame_err_tb;
    uart_tx_pkg::tx_state_t state_dbg_tb;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    uart_tx_ctrl #(
        .DATA_WIDTH(W)
    ) dut (
        .CLK        (CLK_tb),
        .RST        (RST_tb),
        .P_DATA     (P_DATA_tb),
        .DATA_VALID (DATA_VALID_tb),
`ifdef UART_TX_PARITY_EN
        .PAR_EN     (PAR_EN_tb),
        .PAR_TYP    (PAR_TYP_tb),
`endif
        .ser_data   (ser_data_tb),
        .ser_done   (ser_done_tb),
        .ser_p_data (ser_p_data_tb),
        .ser_en     (ser_en_tb),
        .TX_OUT     (TX_OUT_tb),
        .busy       (busy_tb),
        .frame_err  (frame_err_tb),
        .state_dbg  (state_dbg_tb)
    );

    // ---------------- clock ----------------
    initial begin
        CLK_tb = 1'b0;
        forever #5 CLK_tb = ~CLK_tb;
    end

    // ---------------- serializer model ----------------
    // Loads on the first enabled edge, then presents one bit per cycle LSB
    // first; done fires on bit index done_at-1 (8 = well behaved).
    int           done_at = W;
    bit           ser_active;
    int           ser_idx;
    logic [W-1:0] ser_sh;

    always @(posedge CLK_tb or negedge RST_tb) begin
        if (!RST_tb) begin
            ser_active <= 1'b0;
            ser_idx    <= 0;
            ser_sh     <= '0;
        end else if (ser_en_tb) begin
            if (!ser_active) begin
                ser_sh     <= ser_p_data_tb;
                ser_idx    <= 0;
                ser_active <= 1'b1;
            end else begin
                ser_idx <= ser_idx + 1;
            end
        end else begin
            ser_active <= 1'b0;
        end
    end

    assign ser_data_tb = (ser_active && ser_idx < W) ? ser_sh[ser_idx] : 1'b0;
    assign ser_done_tb = ser_active && (ser_idx == done_at - 1);

    // ---------------- frame model ----------------
    // exp_q holds the line bits still to appear, one per cycle, as
    // {tx, ser_en_while_pending, sets_frame_err}.
    logic [2:0]   exp_q[$];
    logic         exp_tx    = 1'b1;
    logic         exp_busy  = 1'b0;
    logic         exp_err   = 1'b0;
    logic [W-1:0] exp_pdata = '0;

    always @(posedge CLK_tb or negedge RST_tb) begin
        if (!RST_tb) begin
            exp_q.delete();
            exp_tx    = 1'b1;
            exp_busy  = 1'b0;
            exp_err   = 1'b0;
            exp_pdata = '0;
        end else begin
            logic [2:0] e;
            logic       can_accept;
            logic       pe;
            logic       pt;
            int         nb;
            can_accept = (exp_q.size() <= 1);
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                exp_tx   = e[2];
                exp_busy = 1'b1;
                if (e[0]) exp_err = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            if (can_accept && DATA_VALID_tb) begin
                pe = 1'b0;
                pt = 1'b0;
`ifdef UART_TX_PARITY_EN
                pe = PAR_EN_tb;
                pt = PAR_TYP_tb;
`endif
                nb = (done_at < W) ? done_at : W;
                exp_pdata = P_DATA_tb;
                exp_q.push_back({1'b0, 1'b1, 1'b0});
                for (int i = 0; i < nb; i++) begin
                    exp_q.push_back({P_DATA_tb[i], 1'b1, (i == nb - 1) && (done_at != W)});
                end
                if (pe) exp_q.push_back({(^P_DATA_tb) ^ pt, 1'b0, 1'b0});
                exp_q.push_back({1'b1, 1'b0, 1'b0});
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare against the model.
    always @(negedge CLK_tb) begin
        if (cmp_on) begin
            logic en_exp;
            en_exp = (exp_q.size() > 0) ? exp_q[0][1] : 1'b0;
            check("tx_out",     32'(TX_OUT_tb),     32'(exp_tx));
            check("busy",       32'(busy_tb),       32'(exp_busy));
            check("frame_err",  32'(frame_err_tb),  32'(exp_err));
            check("ser_en",     32'(ser_en_tb),     32'(en_exp));
            check("ser_p_data", 32'(ser_p_data_tb), 32'(exp_pdata));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge. Sends one byte, disturbs P_DATA and
    // DATA_VALID mid-frame, records len line bits starting at the start bit
    // and counts busy cycles over the frame plus three idle cycles.
    task automatic send_frame(input logic [W-1:0] data, input logic pe, input logic pt,
                              input int len, output logic [31:0] bits, output int busy_cnt);
        P_DATA_tb     = data;
        DATA_VALID_tb = 1'b1;
        PAR_EN_tb     = pe;
        PAR_TYP_tb    = pt;
        @(posedge CLK_tb);
        @(negedge CLK_tb);
        DATA_VALID_tb = 1'b0;
        P_DATA_tb     = W'($urandom);
        PAR_EN_tb     = 1'($urandom);
        PAR_TYP_tb    = 1'($urandom);
        bits     = '0;
        busy_cnt = 0;
        for (int i = 0; i < len + 3; i++) begin
            @(negedge CLK_tb);
            if (i < len) bits[i] = TX_OUT_tb;
            if (busy_tb) busy_cnt++;
            if (i == 3) begin
                DATA_VALID_tb = 1'b1;
                P_DATA_tb     = W'($urandom);
            end
            if (i == 4) DATA_VALID_tb = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] bits;
        int          bc;

        RST_tb        = 1'b0;
        DATA_VALID_tb = 1'b0;
        P_DATA_tb     = '0;
        PAR_EN_tb     = 1'b0;
        PAR_TYP_tb    = 1'b0;
        repeat (3) @(negedge CLK_tb);
        check("rst_tx",     32'(TX_OUT_tb),     32'd1);
        check("rst_busy",   32'(busy_tb),       32'd0);
        check("rst_ser_en", 32'(ser_en_tb),     32'd0);
        check("rst_err",    32'(frame_err_tb),  32'd0);
        check("rst_pdata",  32'(ser_p_data_tb), 32'd0);
        RST_tb = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(negedge CLK_tb);

        // 0x5A plain frame: 0,0,1,0,1,1,0,1,0,1
        send_frame(8'h5A, 1'b0, 1'b0, 10, bits, bc);
        check("frame_5a", bits, 32'h2B4);
        check("busy_5a",  32'(bc), 32'd10);

        // 0xB3 without parity slot: 0,1,1,0,0,1,1,0,1,1
        send_frame(8'hB3, 1'b0, 1'b0, 10, bits, bc);
        check("frame_b3_nopar", bits, 32'h366);
        check("busy_b3_nopar",  32'(bc), 32'd10);

`ifdef UART_TX_PARITY_EN
        // 0xB3 even: parity 1 -> 0,1,1,0,0,1,1,0,1,1,1
        send_frame(8'hB3, 1'b1, 1'b0, 11, bits, bc);
        check("frame_b3_even", bits, 32'h766);
        check("busy_b3_even",  32'(bc), 32'd11);
        // 0xB3 odd: parity 0
        send_frame(8'hB3, 1'b1, 1'b1, 11, bits, bc);
        check("frame_b3_odd", bits, 32'h566);
        check("busy_b3_odd",  32'(bc), 32'd11);
`endif

        // Back-to-back: 0x00 then 0xFF with DATA_VALID held throughout.
        PAR_EN_tb     = 1'b0;
        PAR_TYP_tb    = 1'b0;
        P_DATA_tb     = 8'h00;
        DATA_VALID_tb = 1'b1;
        bits = '0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge CLK_tb);
            if (i >= 2) bits[i-2] = TX_OUT_tb;
            if (i == 1) P_DATA_tb = 8'hFF;
            if (i == 11) begin
                DATA_VALID_tb = 1'b0;
                P_DATA_tb     = 8'h3C;
            end
        end
        check("frame_b2b", bits, 32'hFFA00);
        repeat (3) @(negedge CLK_tb);

        // Serializer signals done after 6 bits: 0,1,1,0,0,1,1,1
        done_at = 6;
        send_frame(8'hB3, 1'b0, 1'b0, 8, bits, bc);
        check("frame_short", bits, 32'hE6);
        check("busy_short",  32'(bc), 32'd8);
        check("err_set",     32'(frame_err_tb), 32'd1);
        done_at = W;
        send_frame(8'h5A, 1'b0, 1'b0, 10, bits, bc);
        check("frame_after_err", bits, 32'h2B4);
        check("err_sticky",      32'(frame_err_tb), 32'd1);

        // Reset while data bit 3 is on the line.
        P_DATA_tb     = 8'hC5;
        DATA_VALID_tb = 1'b1;
        @(posedge CLK_tb);
        @(negedge CLK_tb);
        DATA_VALID_tb = 1'b0;
        repeat (5) @(negedge CLK_tb);
        #2 RST_tb = 1'b0;
        #1;
        check("midrst_tx",     32'(TX_OUT_tb),     32'd1);
        check("midrst_busy",   32'(busy_tb),       32'd0);
        check("midrst_err",    32'(frame_err_tb),  32'd0);
        check("midrst_ser_en", 32'(ser_en_tb),     32'd0);
        @(negedge CLK_tb);
        RST_tb = 1'b1;
        @(negedge CLK_tb);
        send_frame(8'h5A, 1'b0, 1'b0, 10, bits, bc);
        check("frame_after_rst", bits, 32'h2B4);
        check("busy_after_rst",  32'(bc), 32'd10);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            DATA_VALID_tb = ($urandom_range(0, 3) != 0);
            P_DATA_tb     = W'($urandom);
            PAR_EN_tb     = 1'($urandom);
            PAR_TYP_tb    = 1'($urandom);
            if (($urandom_range(0, 99) == 0) && (c < 560)) begin
                DATA_VALID_tb = 1'b0;
                repeat (12) @(negedge CLK_tb);
            end
            @(negedge CLK_tb);
        end
        DATA_VALID_tb = 1'b0;
        repeat (15) @(negedge CLK_tb);
        check("final_idle_busy", 32'(busy_tb),   32'd0);
        check("final_idle_tx",   32'(TX_OUT_tb), 32'd1);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
